booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
- Shares one pipelined 8x8 signed Booth multiplier (`booth_multiplier`) among NREQ requesters.
- Round-robin arbitration and valid/ready handshakes on every request and on the response channel.
- Tags each operation with its requester ID and tracks in-flight operations.
- Buffers results in a small response FIFO, with credit-based issue so backpressure never drops a product.
- Sits between the per-channel operand producers and the shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, equal to clog2(NREQ).
- FIFO_DEPTH, 4, response FIFO entries; also the total credit limit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_x  in  NREQ*8  multiplicands, signed; requester i uses bits [8i+7:8i].
- req_y  in  NREQ*8  multipliers, signed; same packing as req_x.
- resp_valid  out  1  response FIFO head valid.
- resp_ready  in  1  consumer accepts head.
- resp_id  out  ID_W  requester that issued the head operation.
- resp_product  out  16  signed product x*y.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (rst==0 at posedge):
  - RR pointer = 0.
  - Tag pipeline valid bits = 0.
  - FIFO emptied; in-flight counter = 0.
  - resp_valid = 0, busy = 0.
  - req_ready forced to 0 combinationally while rst==0.
  - The multiplier shares rst.
  - Reset mid-operation discards all in-flight and buffered results; no stale response may appear after reset.
- Credit:
  - inflight (0..2) + fifo_count must be < FIFO_DEPTH to issue.
  - Computed from registered state only; no combinational path from resp_ready to req_ready.
  - A pop in the same cycle does not free a credit until the next cycle.
- Arbitration:
  - Scan req_valid starting at the RR pointer, wrapping modulo NREQ; the first set bit is the grant.
  - req_ready[grant] = can_issue; all other ready bits are 0.
  - On a transfer (valid && ready), pointer <= grant+1 mod NREQ.
  - With no transfer, the pointer holds.
  - At most one issue per cycle.
- Issue datapath:
  - Granted operands are muxed onto the multiplier x/y inputs.
  - When no transfer occurs, x = y = 0.
  - The multiplier samples every cycle; it has no enable.
- Latency:
  - Transfer in cycle t: operands are registered at end of t, product is registered at end of t+1 and is valid on the multiplier output in t+2.
  - A 2-stage tag pipeline {valid, id} aligns with the multiplier.
  - Push into the FIFO at end of t+2.
  - resp_valid is asserted no earlier than cycle t+3.
- inflight counter: +1 on issue, -1 on tag-stage-2 push; both together = no change.
- Product width:
  - resp_product = multiplier result[15:0]; the multiplier carry output is ignored.
  - The signed 8x8 product is exact in 16 bits.
  - -128*-128 = 0x4000.
- FIFO:
  - First-word-fall-through; resp_valid = !empty.
  - Pop on resp_valid && resp_ready.
  - Simultaneous push and pop are legal at any occupancy.
  - resp_id and resp_product hold stable while resp_valid && !resp_ready.
  - Push when full is impossible by credit; assert it.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by a count register.
- Ordering: responses are returned in global issue order; for a single requester this is its request order.
- busy = (inflight != 0) || !empty.

Decomposition:
- Package booth_arb_pkg:
  - MULT_LAT = 2.
  - PROD_W = 16, OPND_W = 8.
  - Response struct/typedef {id, product}.
  - clog2 helper for ID_W.
- One sub-module, booth_resp_fifo: parameterised depth/width, sync reset active-low, FWFT, with count output.
- The top instantiates booth_resp_fifo and booth_multiplier.

Test Plan:
1. Single op: requester 2 issues x=-128, y=-128 in cycle t with resp_ready=1 -> resp_valid first high in t+3 with resp_id=2, resp_product=0x4000; busy high in t+1..t+3, then 0.
2. Corners, one op each from requester 0:
   - x=127, y=-128 -> 0xC080.
   - x=-1, y=-1 -> 0x0001.
   - x=0, y=-77 -> 0x0000.
   - x=-128, y=127 -> 0xC080.
3. All four requesters continuously valid, resp_ready=1 -> grants 0,1,2,3,0,... one per cycle; responses carry IDs in the same order at 1/cycle throughput; no credit stall.
4. All valid, resp_ready=0 -> exactly 4 transfers, then req_ready=0; head response held stable.
   - Raise resp_ready -> 4 responses drain in order.
   - Issue resumes one cycle after the first pop.
5. Fairness: requester 0 held valid permanently, requester 3 pulses valid -> requester 3 is granted within NREQ cycles and the pointer advances to 0 afterwards.
6. Reset mid-flight: 3 ops issued, 1 buffered with resp_ready=0, then rst=0 for one cycle:
   - After reset: resp_valid=0, busy=0.
   - A new op from requester 1 returns the correct product only.
   - No stale results appear.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared constants, response record and width helper for the shared Booth multiplier arbiter.
package booth_arb_pkg;

  localparam int MULT_LAT = 2;
  localparam int OPND_W   = 8;
  localparam int PROD_W   = 16;
  localparam int ID_MAX_W = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Response record; id is sized for the largest supported requester count.
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } resp_t;

endpackage

// File: rtl/booth_multiplier.sv
// Two-stage signed radix-4 Booth multiplier: operands registered, then product registered.
module booth_multiplier
  import booth_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  output logic [PROD_W-1:0] product,
  output logic              carry
);

  logic [OPND_W-1:0] x_r, y_r;
  logic [OPND_W:0]   yb;
  logic [PROD_W:0]   xe, pp, acc;

  // Sum of sign-extended partial products modulo 2^17; bit 16 mirrors the sign of the exact product.
  always_comb begin
    xe  = {{(PROD_W + 1 - OPND_W){x_r[OPND_W-1]}}, x_r};
    yb  = {y_r, 1'b0};
    acc = '0;
    pp  = '0;
    for (int k = 0; k < OPND_W / 2; k++) begin
      case (yb[2*k +: 3])
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe << 1;
        3'b100:         pp = -(xe << 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_r     <= '0;
      y_r     <= '0;
      product <= '0;
      carry   <= 1'b0;
    end else begin
      x_r              <= x;
      y_r              <= y;
      {carry, product} <= acc;
    end
  end

endmodule

// File: rtl/booth_resp_fifo.sv
// First-word-fall-through response FIFO; a count register separates full from empty.
module booth_resp_fifo
  import booth_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A pop frees the slot the same cycle, so push is accepted at full alongside a pop.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined Booth multiplier, with tagged results and credit-gated issue.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ID_W       = clog2(NREQ),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OPND_W-1:0]   req_x,
  input  logic [NREQ*OPND_W-1:0]   req_y,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [PROD_W-1:0]        resp_product,
  output logic                     busy
);

  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  // Handshake: a transfer happens on any channel in a cycle where valid && ready are both high at
  // posedge; ready never depends combinationally on resp_ready, and valid may wait on ready.
  logic [ID_W-1:0]   rr_ptr, grant;
  logic              grant_found, can_issue, xfer;
  int                scan;
  logic [1:0]        inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full, push, pop;
  logic [OPND_W-1:0] mult_x, mult_y;
  logic [PROD_W-1:0] mult_p;
  logic              mult_carry;
  logic [MULT_LAT-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [MULT_LAT];
  resp_t             push_data, head;

  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    scan        = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan = (int'(rr_ptr) + i) % NREQ;
      if (!grant_found && req_valid[scan]) begin
        grant_found = 1'b1;
        grant       = ID_W'(scan);
      end
    end
  end

  // Credit uses registered occupancy only, so a same-cycle pop frees its slot one cycle later.
  assign can_issue = rst && ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);
  assign xfer      = grant_found && can_issue;
  assign req_ready = xfer ? (NREQ'(1) << grant) : '0;
  assign mult_x    = xfer ? req_x[grant*OPND_W +: OPND_W] : '0;
  assign mult_y    = xfer ? req_y[grant*OPND_W +: OPND_W] : '0;

  booth_multiplier u_mult (
    .clk     (clk),
    .rst     (rst),
    .x       (mult_x),
    .y       (mult_y),
    .product (mult_p),
    .carry   (mult_carry)
  );

  assign push              = tag_v[MULT_LAT-1];
  assign push_data.id      = ID_MAX_W'(tag_id[MULT_LAT-1]);
  assign push_data.product = mult_p;
  assign pop               = resp_valid && resp_ready;

  booth_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(resp_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign resp_valid   = !fifo_empty;
  assign resp_id      = head.id[ID_W-1:0];
  assign resp_product = head.product;
  assign busy         = (inflight != '0) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr   <= '0;
      inflight <= '0;
      tag_v    <= '0;
      for (int k = 0; k < MULT_LAT; k++) tag_id[k] <= '0;
    end else begin
      if (xfer) rr_ptr <= ID_W'((int'(grant) + 1) % NREQ);
      case ({xfer, push})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
      tag_v     <= {tag_v[MULT_LAT-2:0], xfer};
      tag_id[0] <= grant;
      for (int k = 1; k < MULT_LAT; k++) tag_id[k] <= tag_id[k-1];
      // The product fits in 16 bits, so the discarded carry must equal the sign bit.
      assert (!(push && fifo_full));
      assert (!push || (mult_carry == mult_p[PROD_W-1]));
      assert (!resp_valid || (32'(head.id) < NREQ));
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: table-driven single ops, hand-written corner sequences, random traffic vs. a queue model.
module tb_booth_mult_arbiter;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x, req_y;
  logic              resp_valid, resp_ready;
  logic [ID_W-1:0]   resp_id;
  logic [15:0]       resp_product;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  booth_mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  function automatic logic [7:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'hff;
      3:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // Outstanding operations in issue order; credit = issued-but-not-popped < DEPTH.
  logic [ID_W+15:0] exp_q[$];
  int               cyc_q[$];
  int               rr_ptr = 0;
  int               cyc = 0;

  always @(negedge clk) begin : monitor
    int g;
    logic found;
    logic [NREQ-1:0] exp_ready;
    logic exp_rv;
    logic [ID_W+15:0] head;
    cyc++;
    if (!rst) begin
      check("rst_req_ready", 32'(req_ready), 32'(0));
      exp_q.delete();
      cyc_q.delete();
      rr_ptr = 0;
    end else begin
      found = 1'b0;
      g = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[(rr_ptr + i) % NREQ]) begin
          found = 1'b1;
          g = (rr_ptr + i) % NREQ;
        end
      end
      exp_ready = (found && exp_q.size() < DEPTH) ? NREQ'(1 << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      exp_rv = (exp_q.size() > 0) && (cyc_q[0] + LAT <= cyc);
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (exp_rv) begin
        head = exp_q[0];
        check("resp_id", 32'(resp_id), 32'(head[ID_W+15:16]));
        check("resp_product", 32'(resp_product), 32'(head[15:0]));
        if (resp_ready) begin
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end
      if (exp_ready != '0) begin
        exp_q.push_back({ID_W'(g), ref_mul(req_x[g*8 +: 8], req_y[g*8 +: 8])});
        cyc_q.push_back(cyc);
        rr_ptr = (g + 1) % NREQ;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int id, input logic [7:0] x, input logic [7:0] y);
    req_x[id*8 +: 8] = x;
    req_y[id*8 +: 8] = y;
  endtask

  // One op on an idle DUT; checks latency, busy window and the product against the table value.
  task automatic run_single(input int id, input logic [7:0] x, input logic [7:0] y, input logic [15:0] prod);
    @(posedge clk); #1;
    set_op(id, x, y);
    req_valid  = NREQ'(1 << id);
    resp_ready = 1'b1;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'(1 << id));
    check("single_busy_t", 32'(busy), 32'(0));
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("single_busy", 32'(busy), 32'(k <= 3));
      check("single_resp_valid", 32'(resp_valid), 32'(k == 3));
      if (k == 3) begin
        check("single_id", 32'(resp_id), 32'(id));
        check("single_product", 32'(resp_product), 32'(prod));
      end
    end
  endtask

  typedef struct {
    int          id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] prod;
  } vec_t;

  vec_t tbl[6];

  // ---------------- main sequence ----------------
  initial begin
    int n_xfer;
    logic got;
    logic [NREQ-1:0] acc;

    rst = 1'b0; req_valid = '0; req_x = '0; req_y = '0; resp_ready = 1'b0;
    tbl[0] = '{2, 8'h80, 8'h80, 16'h4000};
    tbl[1] = '{0, 8'h7f, 8'h80, 16'hC080};
    tbl[2] = '{0, 8'hff, 8'hff, 16'h0001};
    tbl[3] = '{0, 8'h00, 8'hB3, 16'h0000};
    tbl[4] = '{0, 8'h80, 8'h7f, 16'hC080};
    tbl[5] = '{3, 8'h64, 8'hfd, 16'hFED4};

    do_reset();
    @(negedge clk);
    check("reset_resp_valid", 32'(resp_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));

    for (int v = 0; v < 6; v++) run_single(tbl[v].id, tbl[v].x, tbl[v].y, tbl[v].prod);

    // Continuous requests with a willing consumer: strict rotation, no credit stall.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 7 - 20), 8'(i + 3));
    req_valid = '1; resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);

    // Backpressure: credits run out after DEPTH transfers, head holds, issue resumes after first pop.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'(-(10 + i)));
    req_valid = '1; resp_ready = 1'b0;
    n_xfer = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_xfer += $countones(req_valid & req_ready);
    end
    check("bp_xfer_count", 32'(n_xfer), 32'(DEPTH));
    check("bp_ready_zero", 32'(req_ready), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_head_valid", 32'(resp_valid), 32'(1));
      check("bp_head_id", 32'(resp_id), 32'(0));
      check("bp_head_prod", 32'(resp_product), 32'(ref_mul(8'd1, 8'(-10))));
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    check("bp_resume_ready", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);

    // Fairness: requester 0 always valid, requester 3 pulses.
    do_reset();
    set_op(0, 8'd9, 8'd9); set_op(3, 8'h81, 8'd2);
    req_valid = 4'b0001; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b1001;
    got = 1'b0;
    for (int k = 0; k < NREQ && !got; k++) begin
      @(negedge clk);
      if (req_ready[3]) got = 1'b1;
    end
    check("fair_grant3", 32'(got), 32'(1));
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("fair_ptr_back_to_0", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);

    // Reset with results in flight and buffered.
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 8'(11 * (i + 1)), 8'(-(i + 2)));
    req_valid = 4'b0111; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    check("mid_head_seen", 32'(got), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_resp_valid", 32'(resp_valid), 32'(0));
      check("post_rst_busy", 32'(busy), 32'(0));
    end
    run_single(1, 8'd37, 8'hfb, 16'hFF47);

    // Random traffic; valid holds until accepted.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, rnd_opnd(), rnd_opnd());
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0; resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
